// File: rtl/drum_pkg.sv
// Shared definitions for the drum solver output path: audio core register map
// and the sink state encoding.
package drum_pkg;

    localparam logic [31:0] AUD_FIFOSPACE_OFS = 32'd4;
    localparam logic [31:0] AUD_LEFT_OFS      = 32'd8;
    localparam logic [31:0] AUD_RIGHT_OFS     = 32'd12;

    typedef enum logic [2:0] {
        IDLE,
        RD_SPACE,
        CHECK,
        WR_LEFT,
        WR_RIGHT
    } sink_state_t;

    // FIFOSPACE[31:16] = {WSLC, WSRC}; a write is safe only if both channels have room.
    function automatic logic space_ok(input logic [15:0] wslc_wsrc);
        return (|wslc_wsrc[15:8]) && (|wslc_wsrc[7:0]);
    endfunction

endpackage

// File: rtl/drum_sample_scale.sv
// Shift a signed node sample left by GAIN_SHIFT, saturate back to IN_W bits and
// left-justify it in a 32-bit audio word.
module drum_sample_scale #(
    parameter int IN_W       = 18,
    parameter int GAIN_SHIFT = 0
) (
    input  logic signed [IN_W-1:0] sample,
    output logic        [31:0]     word
);

    localparam int W = IN_W + GAIN_SHIFT;

    localparam logic [IN_W-1:0] SAT_MAX = {1'b0, {(IN_W-1){1'b1}}};
    localparam logic [IN_W-1:0] SAT_MIN = {1'b1, {(IN_W-1){1'b0}}};

    logic signed [W-1:0]    scaled;
    logic        [IN_W-1:0] sat;

    // The value fits in IN_W bits only when every bit above the new sign bit
    // matches the true sign.
    always_comb begin
        scaled = W'(sample) <<< GAIN_SHIFT;
        if (scaled[W-1:IN_W-1] != {(GAIN_SHIFT+1){scaled[W-1]}})
            sat = scaled[W-1] ? SAT_MIN : SAT_MAX;
        else
            sat = scaled[IN_W-1:0];
    end

    assign word = {sat, {(32-IN_W){1'b0}}};

endmodule

// File: rtl/drum_audio_sink.sv
// Drum solver sample sink: converts each accepted sample to an audio word, polls
// the audio core FIFOSPACE and writes the word to both channels over Avalon-MM.
module drum_audio_sink
    import drum_pkg::*;
#(
    parameter int          IN_W       = 18,
    parameter int          GAIN_SHIFT = 0,
    parameter logic [31:0] AUD_BASE   = 32'hFF20_3040
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic signed [IN_W-1:0] sample_in,
    input  logic                   sample_valid,
    output logic                   sample_ready,
    output logic        [31:0]     bus_addr,
    output logic                   bus_read,
    output logic                   bus_write,
    output logic        [31:0]     bus_writedata,
    input  logic        [31:0]     bus_readdata,
    input  logic                   bus_waitrequest,
    output logic        [31:0]     samples_sent
);

    sink_state_t state, state_nxt;
    logic [31:0] word, scaled_word;
    logic        space_good;

    // Only the channel-space bytes of FIFOSPACE matter to this sink.
    logic readdata_unused;
    assign readdata_unused = ^bus_readdata[15:0];

    drum_sample_scale #(
        .IN_W      (IN_W),
        .GAIN_SHIFT(GAIN_SHIFT)
    ) u_scale (
        .sample(sample_in),
        .word  (scaled_word)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            word         <= '0;
            space_good   <= 1'b0;
            samples_sent <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && sample_valid)
                word <= scaled_word;
            if (state == RD_SPACE && !bus_waitrequest)
                space_good <= space_ok(bus_readdata[31:16]);
            if (state == WR_RIGHT && !bus_waitrequest)
                samples_sent <= samples_sent + 32'd1;
        end
    end

    // Bus outputs decode purely from registered state, so they hold steady under waitrequest.
    always_comb begin
        state_nxt     = state;
        sample_ready  = 1'b0;
        bus_read      = 1'b0;
        bus_write     = 1'b0;
        bus_addr      = '0;
        bus_writedata = '0;
        case (state)
            IDLE: begin
                sample_ready = 1'b1;
                if (sample_valid)
                    state_nxt = RD_SPACE;
            end
            RD_SPACE: begin
                bus_read = 1'b1;
                bus_addr = AUD_BASE + AUD_FIFOSPACE_OFS;
                if (!bus_waitrequest)
                    state_nxt = CHECK;
            end
            CHECK: begin
                state_nxt = space_good ? WR_LEFT : RD_SPACE;
            end
            WR_LEFT: begin
                bus_write     = 1'b1;
                bus_addr      = AUD_BASE + AUD_LEFT_OFS;
                bus_writedata = word;
                if (!bus_waitrequest)
                    state_nxt = WR_RIGHT;
            end
            WR_RIGHT: begin
                bus_write     = 1'b1;
                bus_addr      = AUD_BASE + AUD_RIGHT_OFS;
                bus_writedata = word;
                if (!bus_waitrequest)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_drum_audio_sink.sv
// Scoreboard bench for drum_audio_sink: a G=0 and a G=2 instance share stimulus and
// a randomly stalling Avalon slave; a negedge monitor checks against queued expectations.
module tb_drum_audio_sink;

    localparam logic [31:0] FS_A    = 32'hFF20_3044;
    localparam logic [31:0] LEFT_A  = 32'hFF20_3048;
    localparam logic [31:0] RIGHT_A = 32'hFF20_304C;

    typedef struct {
        logic [31:0] w0;
        logic [31:0] w2;
        int          nrd;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [17:0] sample_in = '0;
    logic        sample_valid = 1'b0;
    logic [31:0] bus_readdata = '0;
    logic        bus_waitrequest = 1'b0;

    logic        r0, w0, ready0, r2, w2, ready2;
    logic [31:0] a0, d0, sent0, a2, d2, sent2;

    always #5 clk = ~clk;

    drum_audio_sink #(.IN_W(18), .GAIN_SHIFT(0), .AUD_BASE(32'hFF20_3040)) dut0 (
        .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
        .sample_ready(ready0), .bus_addr(a0), .bus_read(r0), .bus_write(w0),
        .bus_writedata(d0), .bus_readdata(bus_readdata),
        .bus_waitrequest(bus_waitrequest), .samples_sent(sent0)
    );

    drum_audio_sink #(.IN_W(18), .GAIN_SHIFT(2), .AUD_BASE(32'hFF20_3040)) dut2 (
        .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
        .sample_ready(ready2), .bus_addr(a2), .bus_read(r2), .bus_write(w2),
        .bus_writedata(d2), .bus_readdata(bus_readdata),
        .bus_waitrequest(bus_waitrequest), .samples_sent(sent2)
    );

    // Reference conversion: integer multiply, clamp, left-justify.
    function automatic logic [31:0] model_word(input logic [17:0] s, input int g);
        int v;
        v = $signed(s);
        v = v * (1 << g);
        if (v > 131071) v = 131071;
        if (v < -131072) v = -131072;
        return (32'(v) & 32'h0003_FFFF) << 14;
    endfunction

    function automatic bit sp_good(input logic [31:0] v);
        return (v[31:24] != 8'd0) && (v[23:16] != 8'd0);
    endfunction

    exp_t        exp_q[$];
    logic [31:0] space_q[$];
    logic [31:0] pend_sp[$];

    int total = 0;
    int bad = 0;
    int tmo_cnt = 0;
    int wait_pct = 0;
    int stall_req = 0;
    bit done = 0;

    // monitor / slave state
    int          stall_ctr = 0;
    int          cnt = 0;
    int          rd_cnt = 0;
    int          exp_next = 0;
    bit          exp_ready = 1;
    bit          wphase = 0;
    bit          last_good = 0;
    bit          rst_pend = 0;
    bit          hold_v = 0;
    bit          fin = 0;
    logic [31:0] p_addr, p_data;
    logic [1:0]  p_strb;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        bit term, wt;
        int nxt;
        term = (stall_ctr != 0) && w0 && (a0 == LEFT_A);
        wt = term || ($urandom_range(0, 99) < wait_pct);
        bus_waitrequest = wt;
        bus_readdata = (space_q.size() != 0) ? space_q[0] : 32'd0;
        if (term) stall_ctr--;

        if (rst_pend) begin
            chk("rst_strobes0", {30'd0, r0, w0}, 32'd0);
            chk("rst_strobes2", {30'd0, r2, w2}, 32'd0);
            chk("rst_addr", a0, 32'd0);
            chk("rst_data", d0, 32'd0);
            chk("rst_sent0", sent0, 32'd0);
            chk("rst_sent2", sent2, 32'd0);
            chk("rst_ready", {31'd0, ready0}, 32'd1);
        end
        rst_pend = 0;

        if (!rst) begin
            exp_q.delete();
            space_q.delete();
            cnt = 0; rd_cnt = 0; exp_next = 0; exp_ready = 1;
            wphase = 0; hold_v = 0; stall_ctr = 0;
            rst_pend = 1;
        end else begin
            chk("ready0", {31'd0, ready0}, {31'd0, exp_ready});
            chk("ready2", {31'd0, ready2}, {31'd0, exp_ready});
            chk("sent0", sent0, cnt);
            chk("sent2", sent2, cnt);
            chk("rd_wr_excl", {31'd0, r0 & w0}, 32'd0);
            if (hold_v) begin
                chk("hold_addr", a0, p_addr);
                chk("hold_data", d0, p_data);
                chk("hold_strb", {30'd0, r0, w0}, {30'd0, p_strb});
            end
            case (exp_next)
                1: begin
                    chk("read_strobe", {30'd0, r0, w0}, 32'd2);
                    chk("read_addr", a0, FS_A);
                end
                2: chk("check_idle", {30'd0, r0, w0}, 32'd0);
                3: begin
                    chk("left_strobe", {30'd0, r0, w0}, 32'd1);
                    chk("left_addr", a0, LEFT_A);
                end
                4: begin
                    chk("right_strobe", {30'd0, r0, w0}, 32'd1);
                    chk("right_addr", a0, RIGHT_A);
                end
                default: ;
            endcase
            nxt = 0;
            if (exp_next == 2) nxt = last_good ? 3 : 1;
            if (sample_valid && ready0) begin
                exp_ready = 0;
                nxt = 1;
                stall_ctr = stall_req;
            end
            if (r0 && !wt) begin
                rd_cnt++;
                last_good = (space_q.size() != 0) && sp_good(space_q[0]);
                if (space_q.size() != 0) void'(space_q.pop_front());
                nxt = 2;
            end
            if (w0 && !wt) begin
                if (exp_q.size() == 0) begin
                    chk("exp_q_size", exp_q.size(), 32'd1);
                end else if (!wphase) begin
                    chk("left_data0", d0, exp_q[0].w0);
                    chk("left_data2", d2, exp_q[0].w2);
                    chk("left_addr0", a0, LEFT_A);
                    chk("left_addr2", a2, LEFT_A);
                    chk("read_count", rd_cnt, exp_q[0].nrd);
                    wphase = 1;
                    nxt = 4;
                end else begin
                    chk("right_data0", d0, exp_q[0].w0);
                    chk("right_data2", d2, exp_q[0].w2);
                    chk("right_addr0", a0, RIGHT_A);
                    chk("right_addr2", a2, RIGHT_A);
                    void'(exp_q.pop_front());
                    cnt++;
                    exp_ready = 1;
                    wphase = 0;
                    rd_cnt = 0;
                end
            end
            hold_v = (r0 || w0) && wt;
            p_addr = a0; p_data = d0; p_strb = {r0, w0};
            exp_next = nxt;
        end

        if (done && !fin) begin
            chk("timeouts", tmo_cnt, 32'd0);
            chk("leftover", exp_q.size(), 32'd0);
            fin = 1;
        end
    end

    task automatic send(input logic [17:0] s);
        exp_t e;
        bit   got;
        e.nrd = 0;
        foreach (pend_sp[i]) begin
            space_q.push_back(pend_sp[i]);
            if (e.nrd == 0 && sp_good(pend_sp[i])) e.nrd = i + 1;
        end
        pend_sp.delete();
        e.w0 = model_word(s, 0);
        e.w2 = model_word(s, 2);
        exp_q.push_back(e);
        sample_in = s;
        sample_valid = 1'b1;
        got = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (ready0) begin got = 1; break; end
        end
        @(posedge clk); #1;
        sample_valid = 1'b0;
        sample_in = 18'($urandom);
        if (!got) begin
            $display("FAIL send_timeout: sample %h not accepted", s);
            tmo_cnt++;
        end
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && ready0) begin ok = 1; break; end
        end
        @(posedge clk); #1;
        if (!ok) begin
            $display("FAIL idle_timeout: pending=%0d", exp_q.size());
            tmo_cnt++;
        end
    endtask

    initial begin
        logic [31:0] v;
        logic [17:0] s;
        bit          hit;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;

        // directed: basic word, negative, gain saturation, polling
        wait_pct = 0;
        pend_sp.push_back(32'h0101_0000); send(18'h04000); wait_idle();
        pend_sp.push_back(32'h0101_0000); send(18'h3FFFF); wait_idle();
        pend_sp.push_back(32'h0101_0000); send(18'h10000); wait_idle();
        pend_sp.push_back(32'h0101_0000); send(18'h20000); wait_idle();
        pend_sp.push_back(32'h0);
        pend_sp.push_back(32'h0);
        pend_sp.push_back(32'h0100_0000);
        pend_sp.push_back(32'h0101_0000);
        send(18'h1ABCD); wait_idle();

        // stall left write for three cycles
        stall_req = 3;
        pend_sp.push_back(32'h0202_0000); send(18'h0F0F0);
        stall_req = 0;
        wait_idle();

        // reset while the right write is on the bus
        pend_sp.push_back(32'h0101_0000); send(18'h12345);
        hit = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (w0 && a0 == RIGHT_A) begin hit = 1; break; end
        end
        if (!hit) begin
            $display("FAIL right_wait_timeout: no right write seen");
            tmo_cnt++;
        end
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        wait_idle();
        pend_sp.push_back(32'h0101_0000); send(18'h00001); wait_idle();

        // randomized traffic with random stalls and polling
        wait_pct = 35;
        for (int t = 0; t < 40; t++) begin
            for (int b = 0; b < $urandom_range(0, 2); b++) begin
                v = $urandom;
                if ($urandom_range(0, 1) == 1) v[31:24] = 8'd0; else v[23:16] = 8'd0;
                pend_sp.push_back(v);
            end
            v = $urandom;
            v[31:24] = 8'($urandom_range(1, 255));
            v[23:16] = 8'($urandom_range(1, 255));
            pend_sp.push_back(v);
            case ($urandom_range(0, 5))
                0: s = 18'h1FFFF;
                1: s = 18'h20000;
                2: s = 18'h3FFFF;
                default: s = 18'($urandom);
            endcase
            send(s);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        wait_idle();

        done = 1;
        for (int i = 0; i < 10 && !fin; i++) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
